// File: rtl/player_pkg.sv
// Shared definitions for the player command front-end: command codes,
// pending-vector bit indices, opposing-pair layout and FSM states.
package player_pkg;

  localparam int unsigned NUM_CMDS = 10;

  typedef enum logic [3:0] {
    CMD_NOP        = 4'd0,
    CMD_PLAY_PAUSE = 4'd1,
    CMD_MUTE       = 4'd2,
    CMD_NEXT       = 4'd3,
    CMD_PREV       = 4'd4,
    CMD_FWD30      = 4'd5,
    CMD_BACK30     = 4'd6,
    CMD_FWD10      = 4'd7,
    CMD_BACK10     = 4'd8,
    CMD_VOL_UP     = 4'd9,
    CMD_VOL_DOWN   = 4'd10
  } cmd_t;

  // Pending-vector bit index = command code - 1.
  localparam int unsigned IDX_PLAY_PAUSE = 0;
  localparam int unsigned IDX_MUTE       = 1;
  localparam int unsigned IDX_NEXT       = 2;
  localparam int unsigned IDX_PREV       = 3;
  localparam int unsigned IDX_FWD30      = 4;
  localparam int unsigned IDX_BACK30     = 5;
  localparam int unsigned IDX_FWD10      = 6;
  localparam int unsigned IDX_BACK10     = 7;
  localparam int unsigned IDX_VOL_UP     = 8;
  localparam int unsigned IDX_VOL_DOWN   = 9;

  // Opposing pairs are adjacent bits: (NEXT,PREV) (FWD30,BACK30)
  // (FWD10,BACK10) (VOL_UP,VOL_DOWN); pair p = bits FIRST+2p and FIRST+2p+1.
  localparam int unsigned NUM_PAIRS      = 4;
  localparam int unsigned PAIR_FIRST_IDX = IDX_NEXT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Fixed priority: lowest set bit (lowest code) wins.
  function automatic cmd_t prio_code(input logic [NUM_CMDS-1:0] req);
    cmd_t code;
    code = CMD_NOP;
    for (int unsigned i = NUM_CMDS; i > 0; i--) begin
      if (req[i-1]) code = cmd_t'(4'(i));
    end
    return code;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/player_btn_cond.sv
// Per-button conditioning: 2-FF synchronizer, rising-edge detect and,
// when REPEAT_EN is set, hold-to-repeat request generation.
module player_btn_cond
  import player_pkg::*;
#(
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic req_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise;

  // Synchronize the raw level and keep the previous synchronized sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  generate
    if (REPEAT_EN) begin : g_rpt
      localparam int unsigned CNT_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
      localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
      localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
      localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic [CNT_W-1:0] target;
      logic             rep_q;
      logic             rep_d;
      logic             hit;

      // Counter is 1 on the cycle after the edge, so a hit at value N lands
      // exactly N cycles after the previous request; rep_q selects the
      // initial delay versus the steady repeat period.
      always_comb begin
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        hit    = 1'b0;
        target = rep_q ? PERIOD_C : DELAY_C;
        if (!sync2_q) begin
          cnt_d = '0;
          rep_d = 1'b0;
        end else if (rise) begin
          cnt_d = CNT_W'(1);
          rep_d = 1'b0;
        end else if (cnt_q != '0) begin
          if (cnt_q == target) begin
            hit   = 1'b1;
            cnt_d = CNT_W'(1);
            rep_d = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Repeat counter and phase registers.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
          rep_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          rep_q <= rep_d;
        end
      end

      assign req_o = rise | hit;
    end else begin : g_norpt
      assign req_o = rise;
    end
  endgenerate

endmodule

// File: rtl/player_cmd_scheduler.sv
// Button front-end for the Player core: conditions ten buttons, keeps one
// pending request per command, resolves opposing pairs, and issues one
// command at a time by fixed priority over a valid/ready handshake.
module player_cmd_scheduler
  import player_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                play_pause,
  input  logic                next_song,
  input  logic                prev_song,
  input  logic                pass_30s,
  input  logic                back_30s,
  input  logic                pass_10s,
  input  logic                back_10s,
  input  logic                aumenta_volume,
  input  logic                diminui_volume,
  input  logic                mute_btn,
  input  logic                cmd_ready,
  output logic                cmd_valid,
  output logic [3:0]          cmd_code,
  output logic [NUM_CMDS-1:0] pending,
  output logic                overrun
);

  logic [NUM_CMDS-1:0] btn;
  logic [NUM_CMDS-1:0] req;
  logic [NUM_CMDS-1:0] req_eff;
  logic [NUM_CMDS-1:0] hs_clr;
  logic [NUM_CMDS-1:0] pair_clr;
  logic [NUM_CMDS-1:0] pend_q;
  logic [NUM_CMDS-1:0] pend_d;
  logic                ovr_q;
  logic                ovr_d;
  logic                hs;

  state_t state_q;
  state_t state_d;
  logic   valid_q;
  logic   valid_d;
  cmd_t   code_q;
  cmd_t   code_d;

  assign btn[IDX_PLAY_PAUSE] = play_pause;
  assign btn[IDX_MUTE]       = mute_btn;
  assign btn[IDX_NEXT]       = next_song;
  assign btn[IDX_PREV]       = prev_song;
  assign btn[IDX_FWD30]      = pass_30s;
  assign btn[IDX_BACK30]     = back_30s;
  assign btn[IDX_FWD10]      = pass_10s;
  assign btn[IDX_BACK10]     = back_10s;
  assign btn[IDX_VOL_UP]     = aumenta_volume;
  assign btn[IDX_VOL_DOWN]   = diminui_volume;

  generate
    for (genvar g = 0; g < NUM_CMDS; g++) begin : g_btn
      player_btn_cond #(
        .REPEAT_EN     ((g == IDX_VOL_UP) || (g == IDX_VOL_DOWN)),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_cond (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .btn_i  (btn[g]),
        .req_o  (req[g])
      );
    end
  endgenerate

  assign hs = (state_q == ST_ISSUE) && cmd_ready;

  // Pending update: handshake clear first, then pair cancellation, then new
  // requests, so a fresh edge on the in-flight code survives its own clear.
  always_comb begin
    req_eff  = req;
    pair_clr = '0;
    hs_clr   = '0;
    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
      if (req[PAIR_FIRST_IDX + 2*p] || req[PAIR_FIRST_IDX + 2*p + 1]) begin
        pair_clr[PAIR_FIRST_IDX + 2*p]     = 1'b1;
        pair_clr[PAIR_FIRST_IDX + 2*p + 1] = 1'b1;
      end
      if (req[PAIR_FIRST_IDX + 2*p] && req[PAIR_FIRST_IDX + 2*p + 1]) begin
        req_eff[PAIR_FIRST_IDX + 2*p]     = 1'b0;
        req_eff[PAIR_FIRST_IDX + 2*p + 1] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < NUM_CMDS; i++) begin
      if (hs && (code_q == cmd_t'(4'(i + 1)))) hs_clr[i] = 1'b1;
    end
    pend_d = (pend_q & ~hs_clr & ~pair_clr) | req_eff;
    ovr_d  = |(req_eff & pend_q & ~hs_clr);
  end

  // Pending vector and overrun pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  // FSM state register, also registering the handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      code_q  <= CMD_NOP;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  // FSM next-state: arbitrate in IDLE, hold in ISSUE until ready, one GAP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|pend_q) state_d = ST_ISSUE;
      ST_ISSUE: if (cmd_ready) state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: latch the winning code on entry to ISSUE, NOP otherwise.
  always_comb begin
    valid_d = (state_d == ST_ISSUE);
    code_d  = CMD_NOP;
    unique case (state_q)
      ST_IDLE:  if (|pend_q) code_d = prio_code(pend_q);
      ST_ISSUE: if (!cmd_ready) code_d = code_q;
      default:  code_d = CMD_NOP;
    endcase
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;
  assign pending   = pend_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_player_cmd_scheduler.sv
// Directed bench for player_cmd_scheduler with hand-computed expectations.
module tb_player_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       play_pause, next_song, prev_song, pass_30s, back_30s;
  logic       pass_10s, back_10s, aumenta_volume, diminui_volume, mute_btn;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic [9:0] pending;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] hs_codes[$];
  int         hs_times[$];
  int         cyc      = 0;
  int         ov_count = 0;

  always #5 clk = ~clk;

  player_cmd_scheduler #(
    .REPEAT_DELAY  (16),
    .REPEAT_PERIOD (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .play_pause     (play_pause),
    .next_song      (next_song),
    .prev_song      (prev_song),
    .pass_30s       (pass_30s),
    .back_30s       (back_30s),
    .pass_10s       (pass_10s),
    .back_10s       (back_10s),
    .aumenta_volume (aumenta_volume),
    .diminui_volume (diminui_volume),
    .mute_btn       (mute_btn),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .pending        (pending),
    .overrun        (overrun)
  );

  // Record every accepted command and every overrun cycle.
  always @(posedge clk) begin
    cyc++;
    if (reset_n && cmd_valid && cmd_ready) begin
      hs_codes.push_back(cmd_code);
      hs_times.push_back(cyc);
    end
    if (reset_n && overrun) ov_count++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    cycles(2);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", cmd_valid); end
    n_checks++; if (cmd_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", cmd_code); end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL reset_pending: got %0h expected 0", pending); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    reset_n = 1'b1;
    cycles(5);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %0b expected 0", cmd_valid); end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL post_reset_pending: got %0h expected 0", pending); end
  endtask

  task automatic test_single_press;
    int base;
    cmd_ready = 1'b1;
    base = hs_codes.size();
    play_pause = 1'b1;
    cycles(3);
    n_checks++; if (pending !== 10'h001) begin n_fail++; $display("FAIL single_pending_k3: got %0h expected 001", pending); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_k3: got %0b expected 0", cmd_valid); end
    cycles(1);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_k4: got %0b expected 1", cmd_valid); end
    n_checks++; if (cmd_code !== 4'd1) begin n_fail++; $display("FAIL single_code_k4: got %0d expected 1", cmd_code); end
    cycles(1);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_k5: got %0b expected 0", cmd_valid); end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL single_pending_k5: got %0h expected 0", pending); end
    cycles(2);
    play_pause = 1'b0;
    cycles(10);
    n_checks++; if (hs_codes.size() - base !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", hs_codes.size() - base); end
  endtask

  task automatic test_priority;
    int base;
    cmd_ready = 1'b0;
    base = hs_codes.size();
    pass_10s = 1'b1;
    mute_btn = 1'b1;
    cycles(3);
    n_checks++; if (pending !== 10'h042) begin n_fail++; $display("FAIL prio_pending: got %0h expected 042", pending); end
    cycles(1);
    n_checks++; if (cmd_code !== 4'd2 || cmd_valid !== 1'b1) begin n_fail++; $display("FAIL prio_first: got valid %0b code %0d expected valid 1 code 2", cmd_valid, cmd_code); end
    cycles(3);
    pass_10s = 1'b0;
    mute_btn = 1'b0;
    cycles(6);
    n_checks++; if (cmd_code !== 4'd2 || cmd_valid !== 1'b1) begin n_fail++; $display("FAIL prio_stall: got valid %0b code %0d expected valid 1 code 2", cmd_valid, cmd_code); end
    cmd_ready = 1'b1;
    cycles(1);
    n_checks++; if (cmd_valid !== 1'b0 || pending !== 10'h040) begin n_fail++; $display("FAIL prio_gap: got valid %0b pending %0h expected valid 0 pending 040", cmd_valid, pending); end
    cycles(1);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %0b expected 0", cmd_valid); end
    cycles(1);
    n_checks++; if (cmd_code !== 4'd7 || cmd_valid !== 1'b1) begin n_fail++; $display("FAIL prio_second: got valid %0b code %0d expected valid 1 code 7", cmd_valid, cmd_code); end
    cycles(1);
    n_checks++; if (pending !== 10'h000 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL prio_done: got valid %0b pending %0h expected valid 0 pending 0", cmd_valid, pending); end
    cycles(5);
    n_checks++; if (hs_codes.size() - base !== 2) begin n_fail++; $display("FAIL prio_count: got %0d expected 2", hs_codes.size() - base); end
  endtask

  task automatic test_pair_cancel;
    int base;
    // Both members of a pair in the same cycle cancel each other.
    cmd_ready = 1'b1;
    base = hs_codes.size();
    next_song = 1'b1;
    prev_song = 1'b1;
    cycles(3);
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL pair_same_pending: got %0h expected 0", pending); end
    cycles(5);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL pair_same_valid: got %0b expected 0", cmd_valid); end
    next_song = 1'b0;
    prev_song = 1'b0;
    cycles(4);
    n_checks++; if (hs_codes.size() - base !== 0) begin n_fail++; $display("FAIL pair_same_count: got %0d expected 0", hs_codes.size() - base); end
    // Staggered: FSM busy with PLAY_PAUSE so NEXT stays pending, PREV cancels it.
    cmd_ready = 1'b0;
    base = hs_codes.size();
    play_pause = 1'b1;
    cycles(4);
    n_checks++; if (cmd_code !== 4'd1 || cmd_valid !== 1'b1) begin n_fail++; $display("FAIL pair_busy: got valid %0b code %0d expected valid 1 code 1", cmd_valid, cmd_code); end
    next_song = 1'b1;
    play_pause = 1'b0;
    cycles(3);
    n_checks++; if (pending !== 10'h005) begin n_fail++; $display("FAIL pair_next_pending: got %0h expected 005", pending); end
    prev_song = 1'b1;
    cycles(3);
    n_checks++; if (pending !== 10'h009) begin n_fail++; $display("FAIL pair_prev_pending: got %0h expected 009", pending); end
    cmd_ready = 1'b1;
    next_song = 1'b0;
    prev_song = 1'b0;
    cycles(8);
    n_checks++; if (hs_codes.size() - base !== 2) begin n_fail++; $display("FAIL pair_stag_count: got %0d expected 2", hs_codes.size() - base); end
    else begin
      n_checks++; if (hs_codes[base] !== 4'd1 || hs_codes[base+1] !== 4'd4) begin n_fail++; $display("FAIL pair_stag_codes: got %0d,%0d expected 1,4", hs_codes[base], hs_codes[base+1]); end
    end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL pair_stag_pending: got %0h expected 0", pending); end
  endtask

  task automatic test_auto_repeat;
    int base;
    int ovb;
    cmd_ready = 1'b1;
    base = hs_codes.size();
    ovb = ov_count;
    aumenta_volume = 1'b1;
    cycles(40);
    aumenta_volume = 1'b0;
    cycles(12);
    n_checks++; if (hs_codes.size() - base !== 4) begin n_fail++; $display("FAIL rpt_count: got %0d expected 4", hs_codes.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (hs_codes[base+i] !== 4'd9) begin n_fail++; $display("FAIL rpt_code%0d: got %0d expected 9", i, hs_codes[base+i]); end
      end
      n_checks++; if (hs_times[base+1] - hs_times[base] !== 16) begin n_fail++; $display("FAIL rpt_delay: got %0d expected 16", hs_times[base+1] - hs_times[base]); end
      n_checks++; if (hs_times[base+2] - hs_times[base+1] !== 8) begin n_fail++; $display("FAIL rpt_period1: got %0d expected 8", hs_times[base+2] - hs_times[base+1]); end
      n_checks++; if (hs_times[base+3] - hs_times[base+2] !== 8) begin n_fail++; $display("FAIL rpt_period2: got %0d expected 8", hs_times[base+3] - hs_times[base+2]); end
    end
    n_checks++; if (ov_count - ovb !== 0) begin n_fail++; $display("FAIL rpt_overrun: got %0d expected 0", ov_count - ovb); end
    // Non-volume buttons never repeat.
    base = hs_codes.size();
    pass_30s = 1'b1;
    cycles(40);
    pass_30s = 1'b0;
    cycles(12);
    n_checks++; if (hs_codes.size() - base !== 1) begin n_fail++; $display("FAIL norpt_count: got %0d expected 1", hs_codes.size() - base); end
    else begin
      n_checks++; if (hs_codes[base] !== 4'd5) begin n_fail++; $display("FAIL norpt_code: got %0d expected 5", hs_codes[base]); end
    end
  endtask

  task automatic test_coalesce;
    int base;
    int ovb;
    cmd_ready = 1'b0;
    base = hs_codes.size();
    ovb = ov_count;
    back_10s = 1'b1;
    cycles(3);
    back_10s = 1'b0;
    cycles(4);
    n_checks++; if (ov_count - ovb !== 0) begin n_fail++; $display("FAIL coal_first_overrun: got %0d expected 0", ov_count - ovb); end
    back_10s = 1'b1;
    cycles(3);
    back_10s = 1'b0;
    cycles(3);
    n_checks++; if (ov_count - ovb !== 1) begin n_fail++; $display("FAIL coal_overrun_pulses: got %0d expected 1", ov_count - ovb); end
    n_checks++; if (pending !== 10'h080) begin n_fail++; $display("FAIL coal_pending: got %0h expected 080", pending); end
    cmd_ready = 1'b1;
    cycles(8);
    n_checks++; if (hs_codes.size() - base !== 1) begin n_fail++; $display("FAIL coal_count: got %0d expected 1", hs_codes.size() - base); end
    else begin
      n_checks++; if (hs_codes[base] !== 4'd8) begin n_fail++; $display("FAIL coal_code: got %0d expected 8", hs_codes[base]); end
    end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL coal_pending_end: got %0h expected 0", pending); end
  endtask

  task automatic test_reset_mid_issue;
    int base;
    cmd_ready = 1'b0;
    base = hs_codes.size();
    play_pause = 1'b1;
    cycles(4);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_valid: got %0b expected 1", cmd_valid); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0b expected 0", cmd_valid); end
    n_checks++; if (cmd_code !== 4'd0) begin n_fail++; $display("FAIL rst_mid_code: got %0d expected 0", cmd_code); end
    n_checks++; if (pending !== 10'h000) begin n_fail++; $display("FAIL rst_mid_pending: got %0h expected 0", pending); end
    play_pause = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    cycles(10);
    n_checks++; if (hs_codes.size() - base !== 0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", hs_codes.size() - base); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after_valid: got %0b expected 0", cmd_valid); end
  endtask

  task automatic test_reset_hold;
    int base;
    cmd_ready = 1'b1;
    reset_n = 1'b0;
    mute_btn = 1'b1;
    cycles(3);
    base = hs_codes.size();
    reset_n = 1'b1;
    cycles(20);
    n_checks++; if (hs_codes.size() - base !== 1) begin n_fail++; $display("FAIL hold_count: got %0d expected 1", hs_codes.size() - base); end
    else begin
      n_checks++; if (hs_codes[base] !== 4'd2) begin n_fail++; $display("FAIL hold_code: got %0d expected 2", hs_codes[base]); end
    end
    mute_btn = 1'b0;
    cycles(5);
    n_checks++; if (hs_codes.size() - base !== 1) begin n_fail++; $display("FAIL hold_count_end: got %0d expected 1", hs_codes.size() - base); end
  endtask

  initial begin
    reset_n        = 1'b0;
    play_pause     = 1'b0;
    next_song      = 1'b0;
    prev_song      = 1'b0;
    pass_30s       = 1'b0;
    back_30s       = 1'b0;
    pass_10s       = 1'b0;
    back_10s       = 1'b0;
    aumenta_volume = 1'b0;
    diminui_volume = 1'b0;
    mute_btn       = 1'b0;
    cmd_ready      = 1'b0;

    test_reset();
    test_single_press();
    test_priority();
    test_pair_cancel();
    test_auto_repeat();
    test_coalesce();
    test_reset_mid_issue();
    test_reset_hold();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
